// File: rtl/din_conditioner.sv
// din_conditioner: synchronise and debounce a raw async input for the D flip-flop bench.
// Optional macro DIN_COND_EDGE_CNT_EN adds a saturating rise-event counter (edge_cnt).
module din_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    output logic             d_clean,
    output logic             d_clean_n,
    output logic             rise,
    output logic             fall,
`ifdef DIN_COND_EDGE_CNT_EN
    output logic             stable,
    output logic [CNT_W-1:0] edge_cnt
`else
    output logic             stable
`endif
);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   d_nx, rise_nx, fall_nx;

    // Synchroniser chain; runs regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOW;
            cnt     <= '0;
            d_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            d_clean <= d_nx;
            rise    <= rise_nx;
            fall    <= fall_nx;
        end
    end

    // Debounce next-state; en=0 holds state/count and suppresses pulses.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        d_nx     = d_clean;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        if (en) begin
            unique case (state)
                LOW: begin
                    if (s) begin
                        state_nx = WAIT_HI;
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        cnt_nx = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_nx = LOW;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = HIGH;
                        cnt_nx   = '0;
                        d_nx     = 1'b1;
                        rise_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_nx = WAIT_LO;
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        cnt_nx = '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_nx = HIGH;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = LOW;
                        cnt_nx   = '0;
                        d_nx     = 1'b0;
                        fall_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign d_clean_n = ~d_clean;
    assign stable    = (state == LOW) || (state == HIGH);

`ifdef DIN_COND_EDGE_CNT_EN
    // Count rise pulses the cycle after they occur, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (rise && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_din_conditioner.sv
// tb_din_conditioner: randomized and directed checks of din_conditioner
// against a run-length debounce model.
module tb_din_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef DIN_COND_EDGE_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clk = 1'b0;
    logic rst, din, en;
    logic d_clean, d_clean_n, rise, fall, stable;
`ifdef DIN_COND_EDGE_CNT_EN
    logic [CW-1:0] edge_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: delayed samples, accepted level, length of current disagreeing run.
    logic sq[$];
    logic m_level, m_rise, m_fall;
    int   m_run;
    int   m_ecnt;

    din_conditioner #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .en(en),
        .d_clean(d_clean),
        .d_clean_n(d_clean_n),
        .rise(rise),
        .fall(fall),
`ifdef DIN_COND_EDGE_CNT_EN
        .stable(stable),
        .edge_cnt(edge_cnt)
`else
        .stable(stable)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sq = {};
        for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_run   = 0;
        m_ecnt  = 0;
    endtask

    // A level is accepted after DEB consecutive enabled samples disagree with it.
    task automatic model_edge(input logic d, input logic e);
        logic s;
        s = sq.pop_front();
        sq.push_back(d);
        if (m_rise && m_ecnt < (1 << CW) - 1) m_ecnt++;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (e) begin
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
                m_level = s;
                m_rise  = s;
                m_fall  = !s;
                m_run   = 0;
            end
        end
    endtask

    function automatic logic [4:0] exp_vec();
        return {m_level, !m_level, m_rise, m_fall, (m_run == 0)};
    endfunction

    task automatic tick(input logic d, input logic e);
        din = d;
        en  = e;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(d, e);
        #1;
    endtask

    task automatic test_reset();
        int rises;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        vectors++;
        if ({d_clean, d_clean_n, rise, fall, stable} !== 5'b01001) begin
            miscompares++;
            $display("FAIL reset_vals got %b exp %b",
                     {d_clean, d_clean_n, rise, fall, stable}, 5'b01001);
        end
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b1);
            rises += int'(rise);
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_release t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
        vectors++;
        if (rises != 1) begin
            miscompares++;
            $display("FAIL reset_rise_count got %0d exp 1", rises);
        end
    endtask

    task automatic test_falling_bounce();
        int falls;
        logic pat[$];
        pat = {1'b0, 1'b1};
        for (int i = 0; i < 10; i++) pat.push_back(1'b0);
        falls = 0;
        foreach (pat[i]) begin
            tick(pat[i], 1'b1);
            falls += int'(fall);
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL fall_bounce t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
        vectors++;
        if (falls != 1 || d_clean !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_pulse_count got %0d/%b exp 1/0", falls, d_clean);
        end
    endtask

    task automatic test_clean_step();
        int rise_at;
        rise_at = -1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            if (rise && rise_at < 0) rise_at = i;
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL clean_step t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
        vectors++;
        if (rise_at != SYNC + DEB - 1) begin
            miscompares++;
            $display("FAIL step_latency got %0d exp %0d", rise_at, SYNC + DEB - 1);
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic pat[$];
        pat = {};
        for (int i = 0; i < 8; i++) pat.push_back(1'b0);
        for (int i = 0; i < 3; i++) pat.push_back(1'b1);
        for (int i = 0; i < 8; i++) pat.push_back(1'b0);
        rises = 0;
        foreach (pat[i]) begin
            tick(pat[i], 1'b1);
            if (i >= 8) rises += int'(rise);
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL bounce t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
        vectors++;
        if (rises != 0 || d_clean !== 1'b0 || stable !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_reject got %0d/%b/%b exp 0/0/1",
                     rises, d_clean, stable);
        end
    endtask

    task automatic test_enable_freeze();
        int rise_at;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL freeze t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
        rise_at = -1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            if (rise && rise_at < 0) rise_at = i;
        end
        vectors++;
        if (rise_at != 1) begin
            miscompares++;
            $display("FAIL resume_latency got %0d exp 1", rise_at);
        end
    endtask

    task automatic test_mid_wait_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        vectors++;
        if ({d_clean, d_clean_n, rise, fall, stable} !== 5'b01001) begin
            miscompares++;
            $display("FAIL async_reset got %b exp %b",
                     {d_clean, d_clean_n, rise, fall, stable}, 5'b01001);
        end
        model_reset();
        tick(1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
    endtask

`ifdef DIN_COND_EDGE_CNT_EN
    task automatic test_edge_cnt();
        for (int ev = 0; ev < 5; ev++) begin
            for (int i = 0; i < 16; i++) begin
                tick(i < 8, 1'b1);
                vectors++;
                if (edge_cnt !== CW'(m_ecnt)) begin
                    miscompares++;
                    $display("FAIL edge_cnt ev=%0d t=%0d got %0d exp %0d",
                             ev, i, edge_cnt, m_ecnt);
                end
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (edge_cnt !== '0) begin
            miscompares++;
            $display("FAIL edge_cnt_clear got %0d exp 0", edge_cnt);
        end
        model_reset();
        tick(1'b0, 1'b1);
        rst = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic d;
        int   run;
        d = 1'b0;
        run = 0;
        for (int i = 0; i < 2000; i++) begin
            if (run == 0) begin
                d = ~d;
                run = $urandom_range(1, 8);
            end
            run--;
            tick(d, ($urandom_range(0, 9) != 0));
            vectors++;
            if ({d_clean, d_clean_n, rise, fall, stable} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random t=%0d got %b exp %b", i,
                         {d_clean, d_clean_n, rise, fall, stable}, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        en  = 1'b1;
        model_reset();
        test_reset();
        test_falling_bounce();
        test_clean_step();
        test_bounce();
        test_enable_freeze();
        test_mid_wait_reset();
`ifdef DIN_COND_EDGE_CNT_EN
        test_edge_cnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
